piso_stream: RTL and testbench

Parallel-in serial-out stage with valid/ready handshakes on both sides. It takes wide words from the buffer or SRAM side and emits them as a stream of narrow beats, least-significant slice first. It is the producer that feeds the `sipo` deserializer and narrow link interfaces, so a `piso_stream` → `sipo` pair with matching widths reproduces each original word bit-exactly. A one-word holding buffer lets the next word be accepted while the current one is still shifting, so there are no bubbles between words.

---
 rtl/piso_stream.sv | 99 +++++++++
 tb/tb_piso_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_stream.sv
// Parallel-in serial-out stage: wide words in, narrow beats out LSB slice first.
// A one-word holding buffer keeps the output stream gap-free across word boundaries.
module piso_stream #(
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_IN_WIDTH-1:0]  data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      out_last,
    output logic                      busy
);

    localparam int NUM_SHIFTS = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int CNT_W      = $clog2(NUM_SHIFTS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SHIFTS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    if (DATA_IN_WIDTH % DATA_OUT_WIDTH != 0) begin : g_width_check
        $error("piso_stream: DATA_IN_WIDTH must be a multiple of DATA_OUT_WIDTH");
    end

    logic [DATA_IN_WIDTH-1:0] sr;
    logic [DATA_IN_WIDTH-1:0] sr_next;
    logic [DATA_IN_WIDTH-1:0] hb;
    logic [DATA_IN_WIDTH-1:0] hb_next;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_next;
    logic                     hb_valid;
    logic                     hb_valid_next;
    logic                     in_fire;
    logic                     out_fire;

    // in_ready is a pure function of registered state, never of out_ready.
    assign in_ready  = !hb_valid;
    assign out_valid = (cnt != CNT_ZERO);
    assign out_last  = out_valid && (cnt == CNT_ONE);
    assign busy      = out_valid || hb_valid;
    assign data_out  = sr[DATA_OUT_WIDTH-1:0];

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        sr_next       = sr;
        hb_next       = hb;
        cnt_next      = cnt;
        hb_valid_next = hb_valid;
        if (cnt == CNT_ZERO) begin
            if (in_fire) begin
                sr_next  = data_in;
                cnt_next = CNT_FULL;
            end
        end else if (out_fire) begin
            if (cnt > CNT_ONE) begin
                sr_next  = sr >> DATA_OUT_WIDTH;
                cnt_next = cnt - CNT_ONE;
                if (in_fire) begin
                    hb_next       = data_in;
                    hb_valid_next = 1'b1;
                end
            end else if (hb_valid) begin
                sr_next       = hb;
                cnt_next      = CNT_FULL;
                hb_valid_next = 1'b0;
            end else if (in_fire) begin
                // Final beat leaving while a word arrives: load it straight into SR.
                sr_next  = data_in;
                cnt_next = CNT_FULL;
            end else begin
                cnt_next = CNT_ZERO;
            end
        end else if (in_fire) begin
            hb_next       = data_in;
            hb_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr       <= '0;
            hb       <= '0;
            cnt      <= CNT_ZERO;
            hb_valid <= 1'b0;
        end else begin
            sr       <= sr_next;
            hb       <= hb_next;
            cnt      <= cnt_next;
            hb_valid <= hb_valid_next;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream (64 -> 16): reset, single word, back-to-back,
// back-pressure, bypass, reset mid-word and a randomised reassembly round trip.
module tb_piso_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic        out_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    piso_stream #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] beat(input logic [63:0] w, input int k);
        logic [63:0] s;
        s = w >> (16 * k);
        return s[15:0];
    endfunction

    logic [63:0] words [3];
    logic [63:0] exp_q [$];
    logic [63:0] asm_w;
    logic [63:0] exp_w;
    int          wi;
    int          lowrun;
    int          maxlow;
    int          sent;
    int          got;
    int          bidx;
    logic        fire;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        data_in   = 64'h4444_3333_2222_1111;
        out_ready = 1'b1;

        // Reset held three cycles with a word offered.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_data_out", data_out, 0);
            chk("rst_out_last", out_last, 0);
        end
        rst_n = 1'b1;

        // Single word: first beat one cycle after acceptance.
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("single_valid", out_valid, 1);
            chk("single_data", data_out, beat(64'h4444_3333_2222_1111, k));
            chk("single_last", out_last, (k == 3));
            chk("single_busy", busy, 1);
            step();
        end
        chk("single_idle_valid", out_valid, 0);
        chk("single_idle_busy", busy, 0);

        // Back-to-back words, out_ready held high.
        words[0] = 64'h0103_0102_0101_0100;
        words[1] = 64'h0203_0202_0201_0200;
        words[2] = 64'h0303_0302_0301_0300;
        wi = 0; lowrun = 0; maxlow = 0;
        in_valid = 1'b1;
        data_in  = words[0];
        for (int j = 0; j < 12; j++) begin
            fire = in_valid && in_ready;
            step();
            if (fire) wi++;
            in_valid = (wi < 3);
            data_in  = words[(wi < 3) ? wi : 2];
            if (!in_ready) begin
                lowrun++;
                if (lowrun > maxlow) maxlow = lowrun;
            end else begin
                lowrun = 0;
            end
            chk("b2b_valid", out_valid, 1);
            chk("b2b_data", data_out, beat(words[j / 4], j % 4));
            chk("b2b_last", out_last, ((j % 4) == 3));
        end
        chk("b2b_words_taken", wi, 3);
        chk("b2b_inready_low_max", maxlow, 3);
        in_valid = 1'b0;
        step();
        chk("b2b_idle", out_valid, 0);

        // Back-pressure mid-word with a second word captured in HB.
        in_valid = 1'b1;
        data_in  = 64'h1A1A_2A2A_3A3A_4A4A;
        step();
        in_valid = 1'b0;
        chk("bp_a0", data_out, 16'h4A4A);
        step();
        chk("bp_a1", data_out, 16'h3A3A);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 64'h0B04_0B03_0B02_0B01;
        step();
        in_valid = 1'b0;
        chk("bp_hb_in_ready", in_ready, 0);
        chk("bp_hb_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_frozen_data", data_out, 16'h3A3A);
            chk("bp_frozen_last", out_last, 0);
            chk("bp_frozen_in_ready", in_ready, 0);
            step();
        end
        chk("bp_frozen_data_end", data_out, 16'h3A3A);
        out_ready = 1'b1;
        words[0] = 64'h1A1A_2A2A_3A3A_4A4A;
        words[1] = 64'h0B04_0B03_0B02_0B01;
        for (int k = 0; k < 7; k++) begin
            chk("bp_resume_data", data_out, beat(words[(k + 1) / 4], (k + 1) % 4));
            chk("bp_resume_last", out_last, (k == 2) || (k == 6));
            chk("bp_resume_in_ready", in_ready, (k >= 3));
            step();
        end
        chk("bp_idle", out_valid, 0);

        // Word offered on the final beat with HB empty goes straight to SR.
        in_valid = 1'b1;
        data_in  = 64'hF3F3_F2F2_F1F1_F0F0;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        in_valid = 1'b1;
        data_in  = 64'h6363_6262_6161_6060;
        chk("byp_last_data", data_out, 16'hF3F3);
        chk("byp_last_flag", out_last, 1);
        chk("byp_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("byp_no_hb", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            chk("byp_valid", out_valid, 1);
            chk("byp_data", data_out, beat(64'h6363_6262_6161_6060, k));
            step();
        end
        chk("byp_idle", out_valid, 0);

        // Reset mid-word with HB full; nothing of the old words survives.
        in_valid = 1'b1;
        data_in  = 64'hC4C4_C3C3_C2C2_C1C1;
        step();
        data_in = 64'hD4D4_D3D3_D2D2_D1D1;
        step();
        in_valid = 1'b0;
        step();
        chk("mrst_pre_data", data_out, 16'hC3C3);
        chk("mrst_pre_in_ready", in_ready, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_data", data_out, 0);
        step();
        chk("mrst_still_idle", out_valid, 0);
        in_valid = 1'b1;
        data_in  = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("mrst_new_data", data_out, beat(64'hAAAA_BBBB_CCCC_DDDD, k));
            chk("mrst_new_last", out_last, (k == 3));
            step();
        end
        chk("mrst_new_idle", out_valid, 0);

        // Random round trip: reassemble beats into words and compare in order.
        sent = 0; got = 0; bidx = 0; asm_w = '0;
        for (int cyc = 0; cyc < 20000 && got < 200; cyc++) begin
            in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            data_in   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(data_in);
                sent++;
            end
            if (out_valid && out_ready) begin
                asm_w = asm_w | ({48'h0, data_out} << (16 * bidx));
                chk("rt_last", out_last, (bidx == 3));
                if (bidx == 3) begin
                    exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
                    chk("rt_word", asm_w, exp_w);
                    got++;
                    bidx  = 0;
                    asm_w = '0;
                end else begin
                    bidx++;
                end
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rt_words_received", got, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
